// File: rtl/alu_mux_rr_arbiter_if.sv
// Handshake bundle between the requester front-ends and the round-robin arbiter
// that steers the 8:1 ALU operand/result mux.
interface alu_mux_rr_arbiter_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       busy;
  logic       timeout;

  modport master (
    input  req,
    input  done,
    output grant,
    output sel,
    output busy,
    output timeout
  );

  modport slave (
    output req,
    output done,
    input  grant,
    input  sel,
    input  busy,
    input  timeout
  );
endinterface

// File: rtl/alu_mux_rr_arbiter.sv
// Round-robin arbiter for an 8:1 shared ALU datapath; grant held until done or withdrawal.
// Optional forced release after TIMEOUT cycles when ARB_TIMEOUT_EN is defined.
module alu_mux_rr_arbiter #(
  parameter int unsigned NREQ    = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input logic                 clk,
  input logic                 reset,
  alu_mux_rr_arbiter_if.master bus
);

  if (NREQ != 8) begin : g_bad_nreq
    $error("alu_mux_rr_arbiter: NREQ must be 8");
  end
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("alu_mux_rr_arbiter: TIMEOUT must be in 2..255");
  end

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e     state_q, state_d;
  logic [7:0] grant_q, grant_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] win, idx;
  logic       found;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;
`endif

  // Rotating priority search starting at ptr.
  always_comb begin
    win   = ptr_q;
    idx   = ptr_q;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = ptr_q + 3'(k);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StGrant;
          grant_d = 8'b1 << win;
          sel_d   = win;
          ptr_d   = win + 3'd1;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      StGrant: begin
        if (bus.done || !bus.req[sel_q]) begin
          state_d = StIdle;
          grant_d = 8'h00;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d   = StIdle;
          grant_d   = 8'h00;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= 8'h00;
      sel_q   <= 3'd0;
      ptr_q   <= 3'd0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign bus.grant = grant_q;
  assign bus.sel   = sel_q;
  assign bus.busy  = (state_q == StGrant);
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_alu_mux_rr_arbiter.sv
// Directed self-checking bench for alu_mux_rr_arbiter (TIMEOUT=4 when ARB_TIMEOUT_EN is set).
module tb_alu_mux_rr_arbiter;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  alu_mux_rr_arbiter_if bus ();

  alu_mux_rr_arbiter #(
    .NREQ    (8),
    .TIMEOUT (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then check structural invariants away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
    check("inv_onehot", 32'($onehot0(bus.grant)), 32'd1);
    check("inv_busy", 32'(bus.busy), 32'(bus.grant != 8'h00));
    if (bus.busy) check("inv_sel", 32'(bus.grant[bus.sel]), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  int tcount;

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    bus.req  = 8'hFF;
    bus.done = 1'b0;

    // Reset with all requests held
    step();
    step();
    check("rst_grant", 32'(bus.grant), 32'h00);
    check("rst_sel", 32'(bus.sel), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_timeout", 32'(bus.timeout), 32'd0);
    reset = 1'b0;
    step();
    check("first_grant", 32'(bus.grant), 32'h01);
    check("first_sel", 32'(bus.sel), 32'd0);
    bus.done = 1'b1;
    step();
    check("rel_grant", 32'(bus.grant), 32'h00);
    check("rel_sel_hold", 32'(bus.sel), 32'd0);
    bus.done = 1'b0;
    step();
    check("second_grant", 32'(bus.grant), 32'h02);
    check("second_sel", 32'(bus.sel), 32'd1);

    // 16 grants in strict rotation from a fresh pointer
    do_reset();
    step();
    for (int i = 0; i < 16; i++) begin
      check("rr_sel", 32'(bus.sel), 32'(i % 8));
      check("rr_grant", 32'(bus.grant), 32'(1 << (i % 8)));
      bus.done = 1'b1;
      step();
      check("rr_idle", 32'(bus.busy), 32'd0);
      bus.done = 1'b0;
      step();
    end

    // Wrap search: ptr=3, req on lines 7 and 2
    bus.req = 8'h04;
    do_reset();
    step();
    check("ptr3_setup", 32'(bus.sel), 32'd2);
    bus.req = 8'h00;
    step();
    check("withdraw_idle", 32'(bus.grant), 32'h00);
    bus.req = 8'h84;
    step();
    check("wrap_first", 32'(bus.grant), 32'h80);
    check("wrap_first_sel", 32'(bus.sel), 32'd7);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    step();
    check("wrap_second", 32'(bus.grant), 32'h04);
    check("wrap_second_sel", 32'(bus.sel), 32'd2);

    // Withdrawal of line 5 and a stray done while idle
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    bus.req  = 8'h20;
    step();
    check("g5_grant", 32'(bus.grant), 32'h20);
    check("g5_sel", 32'(bus.sel), 32'd5);
    bus.req = 8'h00;
    step();
    check("g5_drop_grant", 32'(bus.grant), 32'h00);
    check("g5_drop_busy", 32'(bus.busy), 32'd0);
    check("g5_sel_hold", 32'(bus.sel), 32'd5);
    bus.done = 1'b1;
    step();
    check("idle_done_grant", 32'(bus.grant), 32'h00);
    check("idle_done_sel", 32'(bus.sel), 32'd5);
    bus.done = 1'b0;

    // Reset mid-grant, then confirm ptr returned to 0
    bus.req = 8'h10;
    step();
    check("g4_grant", 32'(bus.grant), 32'h10);
    reset = 1'b1;
    step();
    check("midrst_grant", 32'(bus.grant), 32'h00);
    check("midrst_sel", 32'(bus.sel), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    reset   = 1'b0;
    bus.req = 8'hFF;
    step();
    check("midrst_ptr0", 32'(bus.grant), 32'h01);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    bus.req  = 8'h10;
    step();
    check("after_rst_g4", 32'(bus.grant), 32'h10);

    // Grant held without done
    bus.req = 8'h01;
    do_reset();
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      step();
      check("to_hold", 32'(bus.grant), 32'h01);
      check("to_quiet", 32'(bus.timeout), 32'd0);
    end
    step();
    check("to_release", 32'(bus.grant), 32'h00);
    check("to_pulse", 32'(bus.timeout), 32'd1);
    step();
    check("to_pulse_end", 32'(bus.timeout), 32'd0);
    check("to_regrant", 32'(bus.grant), 32'h01);
`else
    tcount = 0;
    for (int k = 0; k < 55; k++) begin
      step();
      if (bus.timeout) tcount++;
      if (bus.grant != 8'h01) tcount++;
    end
    check("hold_forever", 32'(tcount), 32'd0);
    check("hold_grant", 32'(bus.grant), 32'h01);
    check("hold_timeout", 32'(bus.timeout), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
